// File: rtl/p10_pkg_common.sv
// Shared types and defaults for the p10 transmit path.
package p10_pkg_common;

  typedef enum logic [1:0] {IDLE, ACK, BUSY, GAP} p10_txq_state_t;

  localparam int P10_TXQ_DEPTH = 16;

  // Bits needed for a counter running 0..max_val-1, never less than one.
  function automatic int p10_cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/p10_sync_fifo.sv
// Synchronous FIFO with registered occupancy level and same-cycle push/pop.
module p10_sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         level_q;
  logic                  do_push;
  logic                  do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  // A write into a full buffer is only taken when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/p10_tx_buf.sv
// Buffers p10 transmit bytes and paces them into the UART one at a time.
// Optional byte statistics (tx_cnt/drop_cnt) when P10_TX_BUF_STATS_EN is defined.
module p10_tx_buf
  import p10_pkg_common::*;
#(
  parameter int DEPTH       = P10_TXQ_DEPTH,
  parameter int DATA_WIDTH  = 8,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 8,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_d,
  input  logic                  in_v,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] out_d,
  output logic                  out_v,
  input  logic                  out_rdy,
  input  logic                  flush,
  output logic [LW-1:0]         level,
  output logic                  ovf,
  output logic                  lost
`ifdef P10_TX_BUF_STATS_EN
  ,
  output logic [15:0]           tx_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES;
  localparam int CW      = p10_cnt_width(CNT_MAX);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  p10_txq_state_t        state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] out_d_q;
  logic                  out_v_q;
  logic                  ovf_q;
  logic                  lost_q;
  logic [DATA_WIDTH-1:0] head;
  logic                  fifo_empty;
  logic                  pop;
  logic                  drop;

  assign pop  = (state_q == IDLE) && !fifo_empty && out_rdy && !flush;
  assign drop = in_v && full && !pop && !flush;

  p10_sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .clear (flush),
    .push  (in_v),
    .pop   (pop),
    .wdata (in_d),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (fifo_empty)
  );

  // cnt_q is shared: ACK timeout while waiting for rdy to drop, then the gap length.
  // flush leaves the handshake of an already launched byte running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_d_q <= '0;
      out_v_q <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      out_v_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            out_d_q <= head;
            out_v_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (!out_rdy) begin
            state_q <= BUSY;
          end else if (cnt_q == ACK_LAST) begin
            lost_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        BUSY: begin
          if (out_rdy) begin
            cnt_q   <= '0;
            state_q <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) state_q <= IDLE;
          else                   cnt_q   <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
      if (drop) ovf_q <= 1'b1;
      if (flush) begin
        ovf_q  <= 1'b0;
        lost_q <= 1'b0;
      end
    end
  end

  assign out_d = out_d_q;
  assign out_v = out_v_q;
  assign ovf   = ovf_q;
  assign lost  = lost_q;

`ifdef P10_TX_BUF_STATS_EN
  logic [15:0] tx_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (flush) begin
      tx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (pop)  tx_cnt_q   <= tx_cnt_q + 16'd1;
      if (drop) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign tx_cnt   = tx_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_p10_tx_buf.sv
// Scoreboard bench for p10_tx_buf with a reactive UART model driving out_rdy.
module tb_p10_tx_buf;

  localparam int DEPTH    = 16;
  localparam int DW       = 8;
  localparam int GAPC     = 5;
  localparam int ACKTO    = 8;
  localparam int LW       = $clog2(DEPTH + 1);
  localparam int BUSY_LEN = 20;

  logic          clk     = 1'b0;
  logic          rst     = 1'b0;
  logic [DW-1:0] in_d    = '0;
  logic          in_v    = 1'b0;
  logic          out_rdy = 1'b1;
  logic          flush   = 1'b0;
  logic          full;
  logic [DW-1:0] out_d;
  logic          out_v;
  logic [LW-1:0] level;
  logic          ovf;
  logic          lost;
`ifdef P10_TX_BUF_STATS_EN
  logic [15:0]   tx_cnt;
  logic [15:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // UART model modes: 0 = normal handshake, 1 = never acknowledges, 2 = held busy
  int uartMode = 0;
  int uartCnt = 0;
  bit uartPend = 1'b0;
  int riseCyc = 0;

  logic [DW-1:0] expQ[$];
  logic [DW-1:0] obsQ[$];
  int            obsT[$];

  p10_tx_buf #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DW),
    .GAP_CYCLES  (GAPC),
    .ACK_TIMEOUT (ACKTO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_d    (in_d),
    .in_v    (in_v),
    .full    (full),
    .out_d   (out_d),
    .out_v   (out_v),
    .out_rdy (out_rdy),
    .flush   (flush),
    .level   (level),
    .ovf     (ovf),
    .lost    (lost)
`ifdef P10_TX_BUF_STATS_EN
    ,
    .tx_cnt   (tx_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record every launch with the cycle it was seen in
  always @(negedge clk) begin
    if (rst === 1'b1 && out_v === 1'b1) begin
      obsQ.push_back(out_d);
      obsT.push_back(cyc);
    end
  end

  // UART: drop rdy the cycle after out_v, raise it BUSY_LEN cycles later
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      uartPend = 1'b0;
      uartCnt  = 0;
      out_rdy  = (uartMode != 2);
    end else if (uartMode == 2) begin
      out_rdy = 1'b0;
    end else if (uartMode == 1) begin
      out_rdy  = 1'b1;
      uartPend = 1'b0;
      uartCnt  = 0;
    end else begin
      if (uartPend) begin
        out_rdy  = 1'b0;
        uartPend = 1'b0;
        uartCnt  = BUSY_LEN;
      end else if (uartCnt > 0) begin
        uartCnt = uartCnt - 1;
        if (uartCnt == 0) begin
          out_rdy = 1'b1;
          riseCyc = cyc;
        end
      end else begin
        out_rdy = 1'b1;
      end
      if (out_v === 1'b1) uartPend = 1'b1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_obs(input int n, input int budget);
    for (int i = 0; i < budget && obsQ.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    uartMode = 0;
    repeat (3) tick();
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
    checks++; if (out_v !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_v got=%b exp=0", out_v); end
    checks++; if (out_d !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_d got=%h exp=00", out_d); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL reset_lost got=%b exp=0", lost); end
`ifdef P10_TX_BUF_STATS_EN
    checks++; if (tx_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_tx_cnt got=%0d exp=0", tx_cnt); end
`endif
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int writeCyc;
    logic [DW-1:0] e, o;
    int t;
    uartMode = 0;
    writeCyc = cyc;
    in_d = 8'hA5; in_v = 1'b1; expQ.push_back(8'hA5);
    tick();
    in_v = 1'b0;
    checks++; if (level !== LW'(1)) begin errors++; $display("[TB] FAIL single_level_after_write got=%0d exp=1", level); end
    wait_obs(1, 20);
    checks++;
    if (obsQ.size() < 1) begin
      errors++; $display("[TB] FAIL single_launch_timeout got=%0d exp=1 launches", obsQ.size());
    end else begin
      e = expQ.pop_front(); o = obsQ.pop_front(); t = obsT.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL single_data got=%h exp=%h", o, e); end
      checks++; if (t !== writeCyc + 2) begin errors++; $display("[TB] FAIL single_latency got=%0d exp=%0d", t - writeCyc, 2); end
    end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL single_level_drained got=%0d exp=0", level); end
    repeat (40) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL single_duplicate got=%0d exp=0 extra launches", obsQ.size()); obsQ.delete(); obsT.delete(); end
  endtask

  task automatic test_burst();
    uartMode = 2;
    repeat (2) tick();
    for (int i = 0; i < 16; i++) begin
      in_d = DW'(i); in_v = 1'b1; expQ.push_back(DW'(i));
      tick();
    end
    in_v = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL burst_full got=%b exp=1", full); end
    checks++; if (level !== LW'(16)) begin errors++; $display("[TB] FAIL burst_level got=%0d exp=16", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL burst_ovf got=%b exp=0", ovf); end
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL burst_launch_while_busy got=%0d exp=0", obsQ.size()); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] e, o;
    in_d = 8'h55; in_v = 1'b1;
    tick();
    in_v = 1'b0;
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set got=%b exp=1", ovf); end
    checks++; if (level !== LW'(16)) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=16", level); end
`ifdef P10_TX_BUF_STATS_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    // rdy rises at the next negedge, so the write below lands on the pop edge
    uartMode = 0;
    tick();
    in_d = 8'h66; in_v = 1'b1; expQ.push_back(8'h66);
    tick();
    in_v = 1'b0;
    checks++; if (level !== LW'(16)) begin errors++; $display("[TB] FAIL ovf_push_on_pop_level got=%0d exp=16", level); end
    checks++; if (obsQ.size() != 1) begin errors++; $display("[TB] FAIL ovf_pop_edge_launch got=%0d exp=1", obsQ.size()); end
    wait_obs(17, 1200);
    checks++;
    if (obsQ.size() < 17) begin
      errors++; $display("[TB] FAIL drain_timeout got=%0d exp=17 launches", obsQ.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsT.pop_front());
        checks++; if (o !== e) begin errors++; $display("[TB] FAIL drain_order[%0d] got=%h exp=%h", i, o, e); end
      end
    end
    repeat (40) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL drain_extra got=%0d exp=0", obsQ.size()); obsQ.delete(); obsT.delete(); end
    expQ.delete();
  endtask

  task automatic test_gap();
    logic [DW-1:0] e, o;
    int t0, t1;
    uartMode = 2;
    repeat (2) tick();
    in_d = 8'h11; in_v = 1'b1; expQ.push_back(8'h11); tick();
    in_d = 8'h22; expQ.push_back(8'h22); tick();
    in_v = 1'b0;
    uartMode = 0;
    wait_obs(2, 200);
    checks++;
    if (obsQ.size() < 2) begin
      errors++; $display("[TB] FAIL gap_timeout got=%0d exp=2 launches", obsQ.size());
    end else begin
      e = expQ.pop_front(); o = obsQ.pop_front(); t0 = obsT.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL gap_first_data got=%h exp=%h", o, e); end
      e = expQ.pop_front(); o = obsQ.pop_front(); t1 = obsT.pop_front();
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL gap_second_data got=%h exp=%h", o, e); end
      // rdy set at negedge of riseCyc, seen at edge riseCyc+1, launch six edges later
      checks++; if (t1 - riseCyc != 7) begin errors++; $display("[TB] FAIL gap_spacing got=%0d exp=7", t1 - riseCyc); end
      checks++; if (t1 - t0 <= BUSY_LEN) begin errors++; $display("[TB] FAIL gap_launch_during_busy got=%0d exp>%0d", t1 - t0, BUSY_LEN); end
    end
    repeat (40) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL gap_extra got=%0d exp=0", obsQ.size()); obsQ.delete(); obsT.delete(); end
    expQ.delete();
  endtask

  task automatic test_lost_ack();
    int writeCyc;
    logic [DW-1:0] e, o;
    int t;
    uartMode = 1;
    tick();
    writeCyc = cyc;
    in_d = 8'h31; in_v = 1'b1; expQ.push_back(8'h31); tick();
    in_d = 8'h32; expQ.push_back(8'h32); tick();
    in_v = 1'b0;
    for (int i = 0; i < 20 && cyc < writeCyc + 9; i++) tick();
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL lost_early got=%b exp=0", lost); end
    tick();
    checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL lost_set got=%b exp=1", lost); end
    wait_obs(2, 20);
    checks++;
    if (obsQ.size() < 2) begin
      errors++; $display("[TB] FAIL lost_next_timeout got=%0d exp=2 launches", obsQ.size());
    end else begin
      e = expQ.pop_front(); o = obsQ.pop_front(); t = obsT.pop_front();
      checks++; if (o !== e || t != writeCyc + 2) begin errors++; $display("[TB] FAIL lost_first got=%h@%0d exp=%h@%0d", o, t, e, writeCyc + 2); end
      e = expQ.pop_front(); o = obsQ.pop_front(); t = obsT.pop_front();
      checks++; if (o !== e || t != writeCyc + 11) begin errors++; $display("[TB] FAIL lost_next got=%h@%0d exp=%h@%0d", o, t, e, writeCyc + 11); end
    end
    repeat (30) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL lost_resent got=%0d exp=0", obsQ.size()); obsQ.delete(); obsT.delete(); end
    expQ.delete();
    uartMode = 0;
    repeat (2) tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] e, o;
    checks++; if (ovf !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_ovf got=%b exp=1", ovf); end
    checks++; if (lost !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_lost got=%b exp=1", lost); end
    for (int i = 0; i < 4; i++) begin
      in_d = DW'(8'h41 + i); in_v = 1'b1;
      if (i == 0) expQ.push_back(8'h41);
      tick();
    end
    in_v = 1'b0;
    wait_obs(1, 20);
    repeat (5) tick();
    flush = 1'b1; in_d = 8'h99; in_v = 1'b1;
    tick();
    flush = 1'b0; in_v = 1'b0;
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL flush_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL flush_full got=%b exp=0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL flush_ovf got=%b exp=0", ovf); end
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL flush_lost got=%b exp=0", lost); end
`ifdef P10_TX_BUF_STATS_EN
    checks++; if (tx_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL flush_stats got=%0d/%0d exp=0/0", tx_cnt, drop_cnt); end
`endif
    checks++;
    if (obsQ.size() < 1) begin
      errors++; $display("[TB] FAIL flush_byte0_missing got=%0d exp=1", obsQ.size());
    end else begin
      e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsT.pop_front());
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL flush_byte0 got=%h exp=%h", o, e); end
    end
    repeat (60) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL flush_leftover got=%0d exp=0", obsQ.size()); obsQ.delete(); obsT.delete(); end
    expQ.delete();
  endtask

  task automatic test_reset_mid_send();
    logic [DW-1:0] e, o;
    uartMode = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_d = DW'(8'h77 + i); in_v = 1'b1;
      tick();
    end
    in_v = 1'b0;
    checks++; if (out_d !== 8'h77 || level !== LW'(2)) begin errors++; $display("[TB] FAIL midack_pre got=%h/%0d exp=77/2", out_d, level); end
    rst = 1'b0;
    #1;
    checks++; if (out_v !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_v got=%b exp=0", out_v); end
    checks++; if (out_d !== 8'h00) begin errors++; $display("[TB] FAIL rst_out_d got=%h exp=00", out_d); end
    checks++; if (level !== '0) begin errors++; $display("[TB] FAIL rst_level got=%0d exp=0", level); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rst_full got=%b exp=0", full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL rst_ovf got=%b exp=0", ovf); end
    checks++; if (lost !== 1'b0) begin errors++; $display("[TB] FAIL rst_lost got=%b exp=0", lost); end
    obsQ.delete(); obsT.delete(); expQ.delete();
    repeat (2) tick();
    rst = 1'b1;
    uartMode = 0;
    repeat (30) tick();
    checks++; if (obsQ.size() != 0) begin errors++; $display("[TB] FAIL rst_spurious_launch got=%0d exp=0", obsQ.size()); obsQ.delete(); obsT.delete(); end
    in_d = 8'h88; in_v = 1'b1; expQ.push_back(8'h88);
    tick();
    in_v = 1'b0;
    wait_obs(1, 20);
    checks++;
    if (obsQ.size() < 1) begin
      errors++; $display("[TB] FAIL rst_resume_timeout got=%0d exp=1", obsQ.size());
    end else begin
      e = expQ.pop_front(); o = obsQ.pop_front(); void'(obsT.pop_front());
      checks++; if (o !== e) begin errors++; $display("[TB] FAIL rst_resume_data got=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_gap();
    test_lost_ack();
    test_flush();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p10_tx_buf.md
Name: p10_tx_buf

Overview:
Byte buffer and pacing stage between the p10 protocol engine transmit output (txd/txv) and the UART transmitter (txd/txv/rdy).
- Absorbs response bursts from p10, which can emit bytes back-to-back.
- Releases one byte at a time only when the UART reports ready.
- Inserts an optional inter-byte gap.
- Flags overflow and byte drops.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, ≥2
DATA_WIDTH, 8, byte width; matches UART DATA_WIDTH
GAP_CYCLES, 0, idle clk cycles inserted after each UART completion before next launch
ACK_TIMEOUT, 8, cycles to wait for UART rdy to drop after a launch before declaring loss

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (asserted at 0)
in_d  input  DATA_WIDTH  byte from p10 (txd)
in_v  input  1  single-cycle write strobe from p10 (txv)
full  output  1  FIFO full
out_d  output  DATA_WIDTH  byte to UART txd
out_v  output  1  single-cycle launch strobe to UART txv
out_rdy  input  1  UART rdy (high = transmitter idle)
flush  input  1  synchronous clear of buffered data and flags
level  output  $clog2(DEPTH+1)  bytes currently buffered
ovf  output  1  sticky: a write was dropped
lost  output  1  sticky: ACK_TIMEOUT expired

Behaviour:
- Reset (rst=0, async): pointers=0, level=0, full=0, out_v=0, out_d=0, ovf=0, lost=0, FSM=IDLE.
- Write:
  - in_v=1 with level<DEPTH stores in_d.
  - in_v=1 with level==DEPTH and a pop in the same cycle is also accepted; level is unchanged.
  - in_v=1 with level==DEPTH and no pop drops the byte and sets ovf=1.
- level is registered and updates the cycle after the write/pop. full = (level==DEPTH).
- Pointers are log2(DEPTH) bits and wrap naturally; level is one bit wider.
- FSM states: IDLE, ACK, BUSY, GAP.
  - IDLE: if level>0 and out_rdy=1, pop the head and register it to out_d. out_v=1 for exactly one cycle, then go to ACK.
  - ACK: wait for out_rdy=0, then go to BUSY. If out_rdy stays 1 for ACK_TIMEOUT cycles, set lost=1 and go to IDLE; the byte is not resent.
  - BUSY: wait for out_rdy=1. Then go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: byte written into an empty buffer with out_rdy=1 → out_v asserted on the 2nd clk edge after the write.
- out_d holds the last launched byte until the next launch.
- Empty buffer: FSM stays in IDLE and out_v stays 0.
- flush=1 (synchronous):
  - Clears pointers, level, ovf and lost.
  - A byte already launched completes its ACK/BUSY/GAP sequence.
  - in_v in the same cycle as flush is discarded.
  - flush takes priority over write and pop.
- Reset mid-send: all state is cleared immediately. No out_v pulse is generated during or after reset release until new data arrives.

Optional Feature:
Macro P10_TX_BUF_STATS_EN.
- Defined: adds outputs tx_cnt[15:0] (bytes launched) and drop_cnt[15:0] (bytes dropped to overflow).
  - Both counters wrap at 0xFFFF→0.
  - Both are cleared by reset and by flush.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package p10_pkg_common:
  - typedef enum p10_txq_state_t {IDLE, ACK, BUSY, GAP}
  - constant P10_TXQ_DEPTH = 16, used as the default by the p10_serial integration
- Sub-module p10_sync_fifo (DEPTH, DATA_WIDTH): memory, pointers, level, full/empty, same-cycle push/pop.
- p10_tx_buf owns the FSM, timeout/gap counters, sticky flags and the optional stats.

Test Plan:
1. Single byte, fast UART: push 0xA5, out_rdy=1, UART model drops rdy 1 cycle after out_v and raises it 20 cycles later → one out_v pulse with out_d=0xA5 on the 2nd edge after the write; level returns to 0.
2. Burst: push 0x00..0x0F back-to-back with DEPTH=16 and the UART busy → full=1 after 16 writes, ovf=0. Bytes then emerge in order 0x00..0x0F with no duplicate out_v.
3. Overflow: while full, push 0x55 with no pop → ovf=1, level stays 16, 0x55 never appears; with STATS_EN, drop_cnt=1. Pushing 0x66 on a pop cycle → accepted and emitted last.
4. Gap: GAP_CYCLES=5, two bytes queued → second out_v exactly 6 cycles after rdy returns high following the first byte.
5. Lost ack: out_rdy held at 1 after out_v → lost=1 after 8 cycles; the next queued byte launches from IDLE; the lost byte is not resent.
6. Flush/reset: queue 4 bytes, assert flush during BUSY of byte 0 → level=0, ovf=0, byte 0 finishes, no further out_v. Then assert rst=0 mid-ACK → all outputs 0 immediately.
